pong_frame_renderer: RTL

//  Parametrised successor to the per-row pong renderer. Owns the LED-matrix row scan, and

---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_row_scanner.sv | 41 ++++
 rtl/pong_frame_renderer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared paddle indices, reset constants and geometry helpers for the pong renderer
package pong_pkg;

  typedef enum logic [1:0] {
    PAD_TOP   = 2'd0,
    PAD_DOWN  = 2'd1,
    PAD_LEFT  = 2'd2,
    PAD_RIGHT = 2'd3
  } paddle_e;

  localparam int NUM_PADDLES  = 4;
  localparam int PAD_MIN      = 1;  // a paddle never covers a corner cell
  localparam int RESET_PADDLE = 1;

  function automatic int clamp_paddle(input int p, input int width, input int size);
    int hi;
    hi = width - 1 - size;
    if (p < PAD_MIN) return PAD_MIN;
    if (p > hi) return hi;
    return p;
  endfunction

  function automatic logic in_span(input int v, input int lo, input int len);
    return (v >= lo) && (v <= lo + len - 1);
  endfunction

endpackage

// File: rtl/pong_row_scanner.sv
// rtl/pong_row_scanner.sv - row hold counter, row counter and frame_start pulse for the LED matrix scan
module pong_row_scanner
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int ROW_HOLD     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [BIT_OF_WIDTH-1:0] row_sel,
  output logic                    frame_start,
  output logic                    advance,
  output logic [BIT_OF_WIDTH-1:0] next_row
);

  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  logic [HW-1:0] hold_cnt;

  assign advance  = (hold_cnt == HW'(ROW_HOLD - 1));
  assign next_row = (row_sel == BIT_OF_WIDTH'(WIDTH - 1)) ? '0 : row_sel + 1'b1;

  // Reset parks the scan at the last row with the hold counter terminal, so the
  // first edge after release starts a fresh frame at row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt    <= HW'(ROW_HOLD - 1);
      row_sel     <= BIT_OF_WIDTH'(WIDTH - 1);
      frame_start <= 1'b0;
    end else if (advance) begin
      hold_cnt    <= '0;
      row_sel     <= next_row;
      frame_start <= (next_row == '0);
    end else begin
      hold_cnt    <= hold_cnt + 1'b1;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/pong_frame_renderer.sv
// rtl/pong_frame_renderer.sv - tear-free pong row renderer with state handshake; optional ball blink via PONG_BALL_BLINK_EN
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int SIZE         = 2,
  parameter int ROW_HOLD     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      state_valid,
  output logic                      state_ready,
  input  logic [BIT_OF_WIDTH-1:0]   player_top,
  input  logic [BIT_OF_WIDTH-1:0]   player_down,
  input  logic [BIT_OF_WIDTH-1:0]   player_left,
  input  logic [BIT_OF_WIDTH-1:0]   player_right,
  input  logic [2*BIT_OF_WIDTH-1:0] pos_ball,
  output logic [BIT_OF_WIDTH-1:0]   row_sel,
  output logic [WIDTH-1:0]          row_data,
  output logic                      frame_start
);

  typedef logic [BIT_OF_WIDTH-1:0] coord_t;

  coord_t shadow_pad [NUM_PADDLES];
  coord_t active_pad [NUM_PADDLES];
  coord_t src_pad    [NUM_PADDLES];
  coord_t shadow_bx, shadow_by, active_bx, active_by, src_bx, src_by;
  coord_t next_row;
  logic   advance, frame_edge, load, accept, pending, ball_en;

  pong_row_scanner #(
    .WIDTH        (WIDTH),
    .BIT_OF_WIDTH (BIT_OF_WIDTH),
    .ROW_HOLD     (ROW_HOLD)
  ) u_scanner (
    .clk         (clk),
    .rst         (rst),
    .row_sel     (row_sel),
    .frame_start (frame_start),
    .advance     (advance),
    .next_row    (next_row)
  );

  assign state_ready = ~pending;
  assign accept      = state_valid && state_ready;
  assign frame_edge  = advance && (next_row == '0);
  assign load        = frame_edge && pending;

  // Row 0 of a loading frame must already see the shadow copy.
  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      src_pad[i] = load ? shadow_pad[i] : active_pad[i];
    end
    src_bx = load ? shadow_bx : active_bx;
    src_by = load ? shadow_by : active_by;
  end

`ifdef PONG_BALL_BLINK_EN
  localparam int BLINK_PERIOD = 2 * BLINK_FRAMES;
  localparam int FCW          = $clog2(BLINK_PERIOD);

  logic [FCW-1:0] frame_cnt, frame_cnt_next;
  logic           first_frame;

  // The frame right after reset is frame 0, so its boundary does not count.
  always_comb begin
    frame_cnt_next = frame_cnt;
    if (frame_edge && !first_frame) begin
      frame_cnt_next = (frame_cnt == FCW'(BLINK_PERIOD - 1)) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign ball_en = (frame_cnt_next < FCW'(BLINK_FRAMES));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      first_frame <= 1'b1;
    end else begin
      frame_cnt <= frame_cnt_next;
      if (frame_edge) first_frame <= 1'b0;
    end
  end
`else
  // Ball is drawn every frame in this build.
  assign ball_en = (BLINK_FRAMES > 0);
`endif

  function automatic logic [WIDTH-1:0] render_row(
    input int   r,
    input int   pl,
    input int   pr,
    input int   pt,
    input int   pd,
    input int   bx,
    input int   by,
    input logic draw_ball
  );
    logic [WIDTH-1:0] bits;
    bits            = '0;
    bits[0]         = in_span(r, pl, SIZE);
    bits[WIDTH-1]   = in_span(r, WIDTH - SIZE - pr, SIZE);
    if (r == 0 || r == WIDTH - 1) begin
      bits[0]       = 1'b1;
      bits[WIDTH-1] = 1'b1;
    end
    for (int c = 1; c <= WIDTH - 2; c++) begin
      if (r == 0 && in_span(c, pt, SIZE)) bits[WIDTH-1-c] = 1'b1;
      if (r == WIDTH - 1 && in_span(c, pd, SIZE)) bits[c] = 1'b1;
      if (draw_ball && r == by && bx == c) bits[c] = 1'b1;
    end
    return bits;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      row_data  <= '0;
      pending   <= 1'b0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        shadow_pad[i] <= coord_t'(RESET_PADDLE);
        active_pad[i] <= coord_t'(RESET_PADDLE);
      end
      shadow_bx <= '0;
      shadow_by <= '0;
      active_bx <= '0;
      active_by <= '0;
    end else begin
      // accept and load are exclusive: accept needs pending=0, load needs pending=1.
      if (accept) begin
        shadow_pad[PAD_TOP]   <= coord_t'(clamp_paddle(int'(player_top), WIDTH, SIZE));
        shadow_pad[PAD_DOWN]  <= coord_t'(clamp_paddle(int'(player_down), WIDTH, SIZE));
        shadow_pad[PAD_LEFT]  <= coord_t'(clamp_paddle(int'(player_left), WIDTH, SIZE));
        shadow_pad[PAD_RIGHT] <= coord_t'(clamp_paddle(int'(player_right), WIDTH, SIZE));
        shadow_bx             <= pos_ball[2*BIT_OF_WIDTH-1:BIT_OF_WIDTH];
        shadow_by             <= pos_ball[BIT_OF_WIDTH-1:0];
        pending               <= 1'b1;
      end
      if (load) begin
        for (int i = 0; i < NUM_PADDLES; i++) begin
          active_pad[i] <= shadow_pad[i];
        end
        active_bx <= shadow_bx;
        active_by <= shadow_by;
        pending   <= 1'b0;
      end
      if (advance) begin
        row_data <= render_row(int'(next_row),
                               int'(src_pad[PAD_LEFT]), int'(src_pad[PAD_RIGHT]),
                               int'(src_pad[PAD_TOP]), int'(src_pad[PAD_DOWN]),
                               int'(src_bx), int'(src_by), ball_en);
      end
    end
  end

endmodule
